// File: rtl/div_sched_if.sv
// Bundle of requester-side and divider-side signals for the divider scheduler.
interface div_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4
);
  // requester side
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] did_in;
  logic [NREQ*W-1:0] dir_in;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      q_out;
  logic [W-1:0]      r_out;
  logic              dz;
  logic              to;
  logic              busy;
  // divider side
  logic              st;
  logic [W-1:0]      did;
  logic [W-1:0]      dir;
  logic              done;
  logic [W-1:0]      q;
  logic [W-1:0]      r;

  modport slave (
    input  req, did_in, dir_in, done, q, r,
    output ack, rsp_valid, q_out, r_out, dz, to, busy, st, did, dir
  );

  modport master (
    output req, did_in, dir_in, done, q, r,
    input  ack, rsp_valid, q_out, r_out, dz, to, busy, st, did, dir
  );
endinterface

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one sequential divider among NREQ requesters.
// Captures operands, pulses the divider start, guards the wait with a watchdog,
// short-circuits divide-by-zero and returns the result to the granted requester.
module div_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst,
  div_sched_if.slave bus
);
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [7:0]      wdog_q, wdog_d;
  logic [W-1:0]    did_q, did_d;
  logic [W-1:0]    dir_q, dir_d;
  logic [W-1:0]    qo_q, qo_d;
  logic [W-1:0]    ro_q, ro_d;
  logic            dz_q, dz_d;
  logic            to_q, to_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   idx;
  logic [W-1:0]    pick_did;
  logic [W-1:0]    pick_dir;
  logic [NREQ-1:0] ack_sel;
  logic [NREQ-1:0] rsp_sel;
  logic [7:0]      wdog_inc;

  // Round-robin search: first set req bit starting just above the last grant.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = GW'((32'(last_q) + i) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Operand mux and one-hot decodes for the picked and the granted requester.
  always_comb begin
    pick_did = '0;
    pick_dir = '0;
    ack_sel  = '0;
    rsp_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GW'(i) == pick) begin
        pick_did   = bus.did_in[i*W +: W];
        pick_dir   = bus.dir_in[i*W +: W];
        ack_sel[i] = 1'b1;
      end
      rsp_sel[i] = (GW'(i) == gnt_q);
    end
  end

  assign wdog_inc = wdog_q + 8'd1;

  // Next-state and register updates for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wdog_d  = wdog_q;
    did_d   = did_q;
    dir_d   = dir_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dz_d    = dz_q;
    to_d    = to_q;
    ack_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d = pick;
          did_d = pick_did;
          dir_d = pick_dir;
          ack_d = ack_sel;
          if (pick_dir == '0) begin
            // Divide-by-zero never touches the divider.
            qo_d    = '1;
            ro_d    = pick_did;
            dz_d    = 1'b1;
            to_d    = 1'b0;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        wdog_d = wdog_inc;
        // done has priority over an expiring watchdog in the same cycle.
        if (bus.done) begin
          qo_d    = bus.q;
          ro_d    = bus.r;
          dz_d    = 1'b0;
          to_d    = 1'b0;
          state_d = StResp;
        end else if (wdog_inc == 8'(TIMEOUT)) begin
          qo_d    = '1;
          ro_d    = '1;
          dz_d    = 1'b0;
          to_d    = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset gives requester 0 top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= GW'(NREQ - 1);
      gnt_q   <= '0;
      wdog_q  <= '0;
      did_q   <= '0;
      dir_q   <= '0;
      qo_q    <= '0;
      ro_q    <= '0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wdog_q  <= wdog_d;
      did_q   <= did_d;
      dir_q   <= dir_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rsp_valid = (state_q == StResp) ? rsp_sel : '0;
  assign bus.q_out     = qo_q;
  assign bus.r_out     = ro_q;
  assign bus.dz        = dz_q;
  assign bus.to        = to_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.st        = (state_q == StIssue);
  assign bus.did       = did_q;
  assign bus.dir       = dir_q;
endmodule
